ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter. It sends one command byte, such as keyboard LED set 0xED or reset 0xFF, to the attached keyboard over the same PS2 clock/data pair that the keyboard receiver listens on. It drives both lines open-collector through drive-low enables; the top-level tristate buffers use `oe=1` to pull low and `oe=0` to release. It runs alongside the receiver, which must see line activity only after this block releases the lines.

---
 rtl/ps2_host_tx.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte to the attached
// device over the shared PS/2 clock/data pair. Both lines are driven
// open-collector: an *_oe output of 1 pulls the line low, 0 releases it.
//
// Ports
//   clk          system clock
//   reset        asynchronous active-low reset
//   KEYSIG_CLK   PS/2 clock line as read back (asynchronous)
//   KEYSIG_DATA  PS/2 data line as read back (asynchronous)
//   tx_data      byte to send, latched when a request is accepted
//   tx_start     one-cycle request strobe, honoured only when idle
//   ps2_clk_oe   1 = pull PS/2 clock low
//   ps2_data_oe  1 = pull PS/2 data low
//   busy         high from the accepted request until done
//   done         one-cycle completion pulse
//   err          missing acknowledge or timeout; valid at done, held
//                until the next accepted request
//
// State table
//   state    | meaning
//   IDLE     | lines released, waiting for tx_start
//   INHIBIT  | clock held low for INHIBIT_CYCLES cycles
//   RTS      | request-to-send: clock and data both held low, one cycle
//   SEND     | clock released, shifting start/data/parity/stop on device clock
//   ACK      | data released, sampling the device acknowledge
//   WAIT_REL | waiting for the device to release both lines
//   FIN      | done pulse, then back to IDLE

module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       KEYSIG_CLK,
    input  logic       KEYSIG_DATA,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_INHIBIT  = 3'd1;
    localparam logic [2:0] S_RTS      = 3'd2;
    localparam logic [2:0] S_SEND     = 3'd3;
    localparam logic [2:0] S_ACK      = 3'd4;
    localparam logic [2:0] S_WAIT_REL = 3'd5;
    localparam logic [2:0] S_FIN      = 3'd6;

    // Down-counters are loaded with N-1 so the terminal count (zero) falls
    // on the last cycle of an N-cycle interval.
    localparam logic [13:0] INH_LOAD = 14'(INHIBIT_CYCLES - 1);
    localparam logic [20:0] TO_LOAD  = 21'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [13:0] inh_cnt_q, inh_cnt_d;
    logic [20:0] to_cnt_q, to_cnt_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic        data_oe_q, data_oe_d;
    logic        err_q, err_d;

    logic kclk_s1_q, kclk_s2_q, kclk_prev_q;
    logic kdat_s1_q, kdat_s2_q;

    logic fe;
    logic to_active;
    logic to_hit;
    logic cur_bit;

    // Synchronizers reset to 1 so an idle (pulled-up) bus gives no false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kclk_s1_q   <= 1'b1;
            kclk_s2_q   <= 1'b1;
            kclk_prev_q <= 1'b1;
            kdat_s1_q   <= 1'b1;
            kdat_s2_q   <= 1'b1;
        end else begin
            kclk_s1_q   <= KEYSIG_CLK;
            kclk_s2_q   <= kclk_s1_q;
            kclk_prev_q <= kclk_s2_q;
            kdat_s1_q   <= KEYSIG_DATA;
            kdat_s2_q   <= kdat_s1_q;
        end
    end

    assign fe = kclk_prev_q & ~kclk_s2_q;

    assign to_active = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_REL);
    assign to_hit    = to_active && (to_cnt_q == 21'd0);

    // Serial bit order: data LSB first, then odd parity, then stop (released).
    always_comb begin
        if (bit_idx_q < 4'd8) begin
            cur_bit = data_q[bit_idx_q[2:0]];
        end else if (bit_idx_q == 4'd8) begin
            cur_bit = parity_q;
        end else begin
            cur_bit = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        parity_d  = parity_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    data_d    = tx_data;
                    parity_d  = ~^tx_data;
                    err_d     = 1'b0;
                    bit_idx_d = 4'd0;
                    inh_cnt_d = INH_LOAD;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == 14'd0) begin
                    state_d = S_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q - 14'd1;
                end
            end
            S_RTS: begin
                to_cnt_d  = TO_LOAD;
                data_oe_d = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_cnt_d = to_cnt_q - 21'd1;
                    if (fe) begin
                        data_oe_d = ~cur_bit;
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd9) begin
                            state_d = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_cnt_d = to_cnt_q - 21'd1;
                    if (fe) begin
                        err_d   = kdat_s2_q;
                        state_d = S_WAIT_REL;
                    end
                end
            end
            S_WAIT_REL: begin
                if (to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    to_cnt_d = to_cnt_q - 21'd1;
                    if (kclk_s2_q && kdat_s2_q) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            inh_cnt_q <= 14'd0;
            to_cnt_q  <= 21'd0;
            bit_idx_q <= 4'd0;
            data_q    <= 8'd0;
            parity_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            to_cnt_q  <= to_cnt_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode straight from state so reset releases the lines at once
    // and a timeout drops data in the very cycle it fires.
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
    assign ps2_data_oe = (state_q == S_RTS) || ((state_q == S_SEND) && data_oe_q && !to_hit);
    assign busy        = (state_q != S_IDLE) && (state_q != S_FIN);
    assign done        = (state_q == S_FIN);
    assign err         = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_oe, ps2_data_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kclk, kdat;

    // Open-collector bus with pull-ups: low if anybody pulls.
    assign kclk = ~(ps2_clk_oe | dev_clk_low);
    assign kdat = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .KEYSIG_CLK (kclk),
        .KEYSIG_DATA(kdat),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        has_frame;
        logic [10:0] frame;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap = '0;
    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference frame as seen on the wire: start 0, data LSB first,
    // parity making the count of ones odd, stop 1.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 0);
        return {1'b1, p, d, 1'b0};
    endfunction

    // Scoreboard monitor: every done pops one expected response.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check("done_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
            check("done_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("err_at_done", {31'd0, err}, {31'd0, e.err});
                if (e.has_frame) check("frame", {21'd0, cap}, {21'd0, e.frame});
            end
        end
    end

    // mode: 0 device acks, 1 device leaves data high at ack, 2 device silent
    task automatic run_tx(input logic [7:0] d, input int mode, input bit poke,
                          input bit rst_mid, input bit b2b);
        int   half;
        int   dc0;
        int   hi;
        int   doe_hi;
        int   done_at;
        logic doe_m1, doe_m2;
        bit   got_done;
        exp_t e;
        half    = int'($urandom_range(8, 14));
        dc0     = done_cnt;
        cap     = '0;
        doe_m1  = 1'b1;
        doe_m2  = 1'b0;
        done_at = -1;
        if (!rst_mid) begin
            e.err       = (mode != 0);
            e.has_frame = (mode != 2);
            e.frame     = frame_of(d);
            exp_q.push_back(e);
        end

        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_clk_oe", {31'd0, ps2_clk_oe}, 32'd1);

        hi = 0;
        doe_hi = 0;
        while (ps2_clk_oe && hi < INH + 20) begin
            hi++;
            if (ps2_data_oe) doe_hi++;
            @(negedge clk);
        end
        check("clk_oe_high_cycles", hi, INH + 1);
        check("data_oe_before_clk_release", doe_hi, 1);
        cap[0] = kdat;

        if (mode == 2) begin
            for (int j = 1; j <= TMO + 20; j++) begin
                @(negedge clk);
                if (j == TMO - 2) doe_m2 = ps2_data_oe;
                if (j == TMO - 1) doe_m1 = ps2_data_oe;
                if (done) begin
                    done_at = j;
                    break;
                end
            end
            check("timeout_done_cycle", done_at, TMO);
            check("timeout_data_oe_before", {31'd0, doe_m2}, 32'd1);
            check("timeout_data_oe_drop", {31'd0, doe_m1}, 32'd0);
        end else begin
            repeat (half) @(negedge clk);
            for (int k = 0; k <= 10; k++) begin
                dev_clk_low = 1'b1;
                repeat (half) @(negedge clk);
                dev_clk_low = 1'b0;
                if (k == 10) begin
                    dev_data_low = 1'b0;
                    break;
                end
                repeat (half / 2) @(negedge clk);
                cap[k+1] = kdat;
                if (k == 9 && mode == 0) dev_data_low = 1'b1;
                if (k == 3 && poke) begin
                    tx_data  = 8'h55;
                    tx_start = 1'b1;
                    @(negedge clk);
                    tx_start = 1'b0;
                end
                if (k == 4 && rst_mid) begin
                    check("pre_reset_data_oe", {31'd0, ps2_data_oe}, 32'd1);
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("reset_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
                    check("reset_data_oe", {31'd0, ps2_data_oe}, 32'd0);
                    check("reset_busy", {31'd0, busy}, 32'd0);
                    repeat (3) @(negedge clk);
                    rst_n = 1'b1;
                    repeat (20) @(negedge clk);
                    check("reset_no_done", done_cnt - dc0, 0);
                    check("reset_idle_busy", {31'd0, busy}, 32'd0);
                    return;
                end
                repeat (half - half / 2) @(negedge clk);
            end
            got_done = 1'b0;
            for (int i = 0; i < 40; i++) begin
                if (done) begin
                    got_done = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("done_seen", {31'd0, got_done}, 32'd1);
        end

        if (b2b && done) begin
            tx_data  = 8'hA5;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            check("fin_start_ignored_busy", {31'd0, busy}, 32'd0);
            check("fin_start_ignored_clk", {31'd0, ps2_clk_oe}, 32'd0);
        end
        repeat (5) @(negedge clk);
        check("one_done", done_cnt - dc0, 1);
        check("err_held", {31'd0, err}, {31'd0, mode != 0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] rd;
        int         rm;
        repeat (3) @(negedge clk);
        check("reset_clk_oe_init", {31'd0, ps2_clk_oe}, 32'd0);
        check("reset_data_oe_init", {31'd0, ps2_data_oe}, 32'd0);
        check("reset_busy_init", {31'd0, busy}, 32'd0);
        check("reset_done_init", {31'd0, done}, 32'd0);
        check("reset_err_init", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_tx(8'hED, 0, 1'b0, 1'b0, 1'b0);
        run_tx(8'h00, 0, 1'b0, 1'b0, 1'b0);
        run_tx(8'h01, 0, 1'b0, 1'b0, 1'b0);
        run_tx(8'hA3, 1, 1'b0, 1'b0, 1'b0);
        run_tx(8'h3C, 2, 1'b0, 1'b0, 1'b0);
        run_tx(8'h96, 0, 1'b1, 1'b0, 1'b0);
        run_tx(8'h00, 0, 1'b0, 1'b1, 1'b0);
        run_tx(8'hFF, 0, 1'b0, 1'b0, 1'b0);
        run_tx(8'h5A, 0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 8; n++) begin
            rd = 8'($urandom);
            rm = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_tx(rd, rm, 1'b0, 1'b0, 1'b0);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
